// File: rtl/dram_port_arbiter_pkg.sv
// Shared definitions for the two-requester DRAM port arbiter.
// Holds the default widths, the arbiter state enum and the read-tag layout
// that travels through the tag FIFO.
package dram_port_arbiter_pkg;

    localparam int DEF_ADDR_W    = 28;
    localparam int DEF_DATA_W    = 512;
    localparam int DEF_BURST_W   = 7;
    localparam int DEF_TAG_DEPTH = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        WBURST = 1'b1
    } state_t;

    // One entry per accepted read burst: who asked and how many beats to expect.
    // The burst field is sized at the default burst width, so BURST_W must not
    // exceed DEF_BURST_W.
    typedef struct packed {
        logic                   id;
        logic [DEF_BURST_W-1:0] burstcount;
    } tag_t;

endpackage

// File: rtl/dram_port_arbiter_tag_fifo.sv
// tag_fifo: synchronous FIFO of outstanding read tags.
// Ports:
//   clk, reset_n      - clock and asynchronous active-low reset (empties FIFO)
//   push, push_data   - write an entry (ignored when full)
//   pop               - discard the head entry (ignored when empty)
//   head              - current head entry (valid when !empty)
//   full, empty       - occupancy flags
//   count             - current occupancy, 0..DEPTH
// Push and pop in the same cycle both take effect.
module tag_fifo
    import dram_port_arbiter_pkg::*;
#(
    parameter int WIDTH = $bits(tag_t),
    parameter int DEPTH = DEF_TAG_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (occ == (AW+1)'(DEPTH));
    assign empty = (occ == '0);
    assign count = occ;

endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one Avalon-MM DRAM port between two requesters.
// Ports:
//   clk, reset_n                    - clock, asynchronous active-low reset
//   rq_read/rq_write [1:0]          - per-requester commands
//   rq_address/burstcount/writedata - per-requester command fields
//   rq_waitrequest [1:0]            - per-requester stall
//   rq_readdatavalid [1:0]          - read beat routed to its requester
//   rq_readdata                     - shared read data
//   dram_*                          - EMIF-side Avalon master
//   protocol_err                    - sticky: burstcount 0 or orphan read beat
//   dbg_state, dbg_tag_count        - arbiter state and read tags in flight
// Handshake: a command is transferred in a cycle where (dram_read|dram_write)
// is high and dram_waitrequest is low; the granted requester sees exactly
// dram_waitrequest, every other requester sees waitrequest high.
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_W   = DEF_BURST_W,
    parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [1:0]                    rq_read,
    input  logic [1:0]                    rq_write,
    input  logic [1:0][ADDR_W-1:0]        rq_address,
    input  logic [1:0][BURST_W-1:0]       rq_burstcount,
    input  logic [1:0][DATA_W-1:0]        rq_writedata,
    output logic [1:0]                    rq_waitrequest,
    output logic [1:0]                    rq_readdatavalid,
    output logic [DATA_W-1:0]             rq_readdata,
    output logic [ADDR_W-1:0]             dram_address,
    output logic                          dram_read,
    output logic                          dram_write,
    output logic [DATA_W-1:0]             dram_writedata,
    output logic [BURST_W-1:0]            dram_burstcount,
    input  logic                          dram_waitrequest,
    input  logic [DATA_W-1:0]             dram_readdata,
    input  logic                          dram_readdatavalid,
    output logic                          protocol_err,
    output state_t                        dbg_state,
    output logic [$clog2(TAG_DEPTH):0]    dbg_tag_count
);

    state_t             state;
    state_t             state_nxt;
    logic               owner;
    logic               last_grant;
    logic [BURST_W-1:0] wcnt;
    logic [BURST_W-1:0] rcnt;
    logic [1:0]         active;
    logic               gnt_valid;
    logic               gnt_id;
    logic               accept;
    logic [BURST_W-1:0] eff_bc;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               rdv_hit;
    tag_t               head_tag;
    tag_t               push_tag;
    logic [BURST_W-1:0] head_bc;

    assign accept = (dram_read || dram_write) && !dram_waitrequest;
    // A burstcount of 0 is illegal; it is carried as a single beat.
    assign eff_bc = (dram_burstcount == '0) ? BURST_W'(1) : dram_burstcount;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (accept && dram_write && eff_bc > BURST_W'(1)) state_nxt = WBURST;
            WBURST: if (accept && dram_write && wcnt == BURST_W'(1))  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: grant selection and command/return routing. Everything is
    // qualified by reset_n so outputs take their reset values asynchronously.
    always_comb begin
        // A full tag FIFO makes a read request invisible to arbitration, so a
        // write from the other side can still win.
        active          = rq_write | (rq_read & {2{!fifo_full}});
        gnt_valid       = 1'b0;
        gnt_id          = 1'b0;
        dram_address    = '0;
        dram_read       = 1'b0;
        dram_write      = 1'b0;
        dram_writedata  = '0;
        dram_burstcount = '0;
        rq_waitrequest  = 2'b11;
        rq_readdatavalid = 2'b00;
        if (reset_n) begin
            if (state == WBURST) begin
                gnt_valid = 1'b1;
                gnt_id    = owner;
            end else if (active == 2'b11) begin
                gnt_valid = 1'b1;
                gnt_id    = !last_grant;
            end else if (active[0]) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (active[1]) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
        if (gnt_valid) begin
            dram_address    = rq_address[gnt_id];
            dram_burstcount = rq_burstcount[gnt_id];
            dram_writedata  = rq_writedata[gnt_id];
            dram_write      = rq_write[gnt_id];
            // Reads never issue mid write-burst or into a full tag FIFO.
            dram_read       = rq_read[gnt_id] && !rq_write[gnt_id] &&
                              !fifo_full && (state == IDLE);
            rq_waitrequest[gnt_id] = dram_waitrequest;
        end
        if (rdv_hit) rq_readdatavalid[head_tag.id] = 1'b1;
    end

    assign rq_readdata = dram_readdata;

    // Read-return tracking: rcnt counts beats already delivered for the head tag.
    assign head_bc   = BURST_W'(head_tag.burstcount);
    assign rdv_hit   = reset_n && dram_readdatavalid && !fifo_empty;
    assign fifo_pop  = rdv_hit && (rcnt == head_bc - BURST_W'(1));
    assign fifo_push = accept && dram_read;
    assign push_tag  = '{id: gnt_id, burstcount: DEF_BURST_W'(eff_bc)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            wcnt         <= '0;
            rcnt         <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (accept) last_grant <= gnt_id;
            if (state == IDLE && accept && dram_write) begin
                owner <= gnt_id;
                wcnt  <= eff_bc - BURST_W'(1);
            end else if (state == WBURST && accept && dram_write) begin
                wcnt <= wcnt - BURST_W'(1);
            end
            if (rdv_hit) rcnt <= fifo_pop ? '0 : rcnt + BURST_W'(1);
            if ((accept && state == IDLE && dram_burstcount == '0) ||
                (dram_readdatavalid && fifo_empty))
                protocol_err <= 1'b1;
        end
    end

    tag_fifo #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (push_tag),
        .pop       (fifo_pop),
        .head      (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (dbg_tag_count)
    );

    assign dbg_state = state;

endmodule

// File: doc/dram_port_arbiter.md
DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 28, meaning the DRAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 512, meaning the DRAM word width.
REQ-003 The block SHALL have parameter BURST_W, default 7, meaning the burstcount width.
REQ-004 The block SHALL have parameter TAG_DEPTH, default 16, meaning the maximum outstanding read bursts (power of 2).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 The block SHALL have ports rq_read / rq_write, input, [1:0]: the per-requester Avalon read/write commands.
REQ-008 The block SHALL have ports rq_address, input, [1:0][ADDR_W-1:0]; rq_burstcount, input, [1:0][BURST_W-1:0]; and rq_writedata, input, [1:0][DATA_W-1:0], all per requester.
REQ-009 The block SHALL have ports rq_waitrequest, output, [1:0], and rq_readdatavalid, output, [1:0], per requester.
REQ-010 The block SHALL have port rq_readdata, output, DATA_W bits, shared by both requesters.
REQ-011 The block SHALL have DRAM-side ports dram_address, dram_read, dram_write, dram_writedata, dram_burstcount (outputs) and dram_waitrequest, dram_readdata, dram_readdatavalid (inputs), at the EMIF widths.
REQ-012 The block SHALL have port protocol_err, output, 1 bit: a sticky error flag.

Function
REQ-013 A command SHALL be accepted in the cycle (dram_read|dram_write) && !dram_waitrequest.
REQ-014 In IDLE, grant SHALL be combinational round-robin: when both requesters are active, the one not granted at the last accepted command wins, and a single active requester wins outright.
REQ-015 The granted requester's address, burstcount, writedata, read and write SHALL pass combinationally to the dram_* ports, and its rq_waitrequest SHALL equal dram_waitrequest.
REQ-016 Every non-granted requester SHALL see rq_waitrequest=1.
REQ-017 With no grant, dram_read=0, dram_write=0 and the other dram_* outputs SHALL be 0.
REQ-018 The last-grant pointer SHALL update only on an accepted command, never on a stalled one.
REQ-019 An accepted write with burstcount>1 SHALL enter state WBURST, locked to its owner, with a beat counter = burstcount-1.
REQ-020 In WBURST, each accepted dram_write SHALL decrement the counter, and the block SHALL return to IDLE in the cycle the counter reaches 0.
REQ-021 In WBURST, the other requester SHALL get no grant.
REQ-022 An accepted read SHALL push {requester id, burstcount} into the tag FIFO in the same cycle.
REQ-023 When the tag FIFO is full, read grants SHALL be suppressed: the reader gets waitrequest=1 and a pending write may still win.
REQ-024 Each dram_readdatavalid SHALL assert rq_readdatavalid[head id] in the same cycle (zero latency), and rq_readdata SHALL equal dram_readdata.
REQ-025 A beat counter SHALL track the head entry; the FIFO SHALL pop on the final beat, and push and pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-026 dram_readdatavalid with the FIFO empty SHALL set protocol_err, drive no rq_readdatavalid and be dropped.
REQ-027 An accepted command with burstcount=0 SHALL set protocol_err and be treated as burstcount 1.
REQ-028 protocol_err SHALL clear only on reset.

Reset
REQ-029 While reset_n=0, the outputs SHALL be dram_read=0, dram_write=0, rq_readdatavalid=0, rq_waitrequest=2'b11 and protocol_err=0.
REQ-030 On reset, the state SHALL go to IDLE, the FIFO SHALL be emptied, the counters SHALL be 0 and last-grant SHALL be 1, so requester 0 wins first.
REQ-031 Reset mid-burst SHALL abandon the burst and drop outstanding tags, and no rq_readdatavalid SHALL be issued for them.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, WBURST), the tag struct {id, burstcount} and the default width constants.
REQ-033 The tag FIFO SHALL be a sub-module, tag_fifo (synchronous, full/empty outputs, depth TAG_DEPTH, same clk/reset_n).

Verification
REQ-034 With both requesters issuing single reads for 4 cycles and no wait, dram_address SHALL alternate 0,1,0,1 starting with requester 0, and readdatavalid SHALL route in the same order.
REQ-035 A requester-1 write burst of 4 issued while requester 0 reads, with dram_waitrequest high in beat 2, SHALL give all 4 beats contiguously to requester 1, hold rq_waitrequest[0]=1 throughout, and then grant requester 0.
REQ-036 With 16 outstanding read bursts (TAG_DEPTH=16) and no returns, the 17th read SHALL stall (waitrequest=1) while a write from the other requester is accepted; the first returned beat SHALL release the stall.
REQ-037 Read bursts of 3 (req0) then 2 (req1) SHALL produce rq_readdatavalid[0] for exactly 3 beats, then [1] for 2 beats, with FIFO occupancy back to 0.
REQ-038 A spurious dram_readdatavalid at idle SHALL set protocol_err=1 and drive no rq_readdatavalid; protocol_err SHALL stay 1 until reset_n pulses low.
REQ-039 A reset_n pulse in the middle of the write burst of REQ-035 SHALL force outputs to their reset values immediately, asynchronously, and the next command after release SHALL go to requester 0.
